// File: rtl/prime_div3_stats.sv
// prime_div3_stats: windowed statistics over a stream of classified nibbles.
// Counts prime, divisible-by-3 and both flags over WIN accepted samples,
// tracks the longest run of consecutive primes, and presents one report per
// window through a valid/ready handshake.
// Optional feature macro: PRIME_DIV3_CHECK_EN. When defined, the classifier
// flags are re-derived from in_nibble and any disagreement sets a sticky err.
`timescale 1ns/1ps

module prime_div3_stats #(
    parameter int CNT_W = 8,
    parameter int WIN   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_nibble,
    input  logic             in_p,
    input  logic             in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_prime_cnt,
    output logic [CNT_W-1:0] out_div3_cnt,
    output logic [CNT_W-1:0] out_both_cnt,
    output logic [CNT_W-1:0] out_max_run,
    output logic             err
);

    typedef enum logic [0:0] {ACCUM, REPORT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] prime_q, prime_d;
    logic [CNT_W-1:0] div3_q, div3_d;
    logic [CNT_W-1:0] both_q, both_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] oprime_q, oprime_d;
    logic [CNT_W-1:0] odiv3_q, odiv3_d;
    logic [CNT_W-1:0] oboth_q, oboth_d;
    logic [CNT_W-1:0] omax_q, omax_d;

    logic             accept;
    logic             handshake;
    logic [CNT_W-1:0] sample_nxt, prime_nxt, div3_nxt, both_nxt, run_nxt, max_nxt;

    // Counters stop at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) return v + CNT_W'(1);
        return v;
    endfunction

    // clear wins over both acceptance and the report handshake.
    assign accept    = (state_q == ACCUM)  && in_valid  && !clear;
    assign handshake = (state_q == REPORT) && out_ready && !clear;

    // Candidate counter values if the presented sample is taken; the max
    // includes the run value produced by this very sample.
    assign sample_nxt = sat_inc(sample_q, 1'b1);
    assign prime_nxt  = sat_inc(prime_q, in_p);
    assign div3_nxt   = sat_inc(div3_q, in_d);
    assign both_nxt   = sat_inc(both_q, in_p & in_d);
    assign run_nxt    = in_p ? sat_inc(run_q, 1'b1) : '0;
    assign max_nxt    = (run_nxt > max_q) ? run_nxt : max_q;

    // Next-state, counter updates, report latching and handshake outputs.
    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        prime_d   = prime_q;
        div3_d    = div3_q;
        both_d    = both_q;
        run_d     = run_q;
        max_d     = max_q;
        oprime_d  = oprime_q;
        odiv3_d   = odiv3_q;
        oboth_d   = oboth_q;
        omax_d    = omax_q;
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == REPORT);

        if (clear || handshake) begin
            state_d  = ACCUM;
            sample_d = '0;
            prime_d  = '0;
            div3_d   = '0;
            both_d   = '0;
            run_d    = '0;
            max_d    = '0;
        end else if (accept) begin
            sample_d = sample_nxt;
            prime_d  = prime_nxt;
            div3_d   = div3_nxt;
            both_d   = both_nxt;
            run_d    = run_nxt;
            max_d    = max_nxt;
            if (sample_nxt == WIN_C) begin
                state_d  = REPORT;
                oprime_d = prime_nxt;
                odiv3_d  = div3_nxt;
                oboth_d  = both_nxt;
                omax_d   = max_nxt;
            end
        end
    end

    // State, window counters and report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            sample_q <= '0;
            prime_q  <= '0;
            div3_q   <= '0;
            both_q   <= '0;
            run_q    <= '0;
            max_q    <= '0;
            oprime_q <= '0;
            odiv3_q  <= '0;
            oboth_q  <= '0;
            omax_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            prime_q  <= prime_d;
            div3_q   <= div3_d;
            both_q   <= both_d;
            run_q    <= run_d;
            max_q    <= max_d;
            oprime_q <= oprime_d;
            odiv3_q  <= odiv3_d;
            oboth_q  <= oboth_d;
            omax_q   <= omax_d;
        end
    end

    assign out_prime_cnt = oprime_q;
    assign out_div3_cnt  = odiv3_q;
    assign out_both_cnt  = oboth_q;
    assign out_max_run   = omax_q;

`ifdef PRIME_DIV3_CHECK_EN
    logic err_q, err_d;
    logic ref_p, ref_d;

    // Reference classification of the nibble.
    always_comb begin
        ref_p = 1'b0;
        ref_d = 1'b0;
        case (in_nibble)
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: ref_p = 1'b1;
            default:                              ref_p = 1'b0;
        endcase
        case (in_nibble)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: ref_d = 1'b1;
            default:                              ref_d = 1'b0;
        endcase
        err_d = err_q | (accept & ((ref_p != in_p) | (ref_d != in_d)));
    end

    // Sticky mismatch flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_nibble;
    assign unused_nibble = ^in_nibble;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_prime_div3_stats.sv
`timescale 1ns/1ps

module tb_prime_div3_stats;

`ifdef PRIME_DIV3_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // Main instance: CNT_W=8, WIN=16
    logic       a_clear, a_iv, a_ir, a_p, a_d, a_ov, a_or, a_err;
    logic [3:0] a_nib;
    logic [7:0] a_pc, a_dc, a_bc, a_mr;

    prime_div3_stats #(.CNT_W(8), .WIN(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_iv), .in_ready(a_ir),
        .in_nibble(a_nib), .in_p(a_p), .in_d(a_d), .out_valid(a_ov), .out_ready(a_or),
        .out_prime_cnt(a_pc), .out_div3_cnt(a_dc), .out_both_cnt(a_bc),
        .out_max_run(a_mr), .err(a_err)
    );

    // Saturation instance: CNT_W=4, WIN=15
    logic       s_clear, s_iv, s_ir, s_p, s_d, s_ov, s_or, s_err;
    logic [3:0] s_nib;
    logic [3:0] s_pc, s_dc, s_bc, s_mr;

    prime_div3_stats #(.CNT_W(4), .WIN(15)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .in_valid(s_iv), .in_ready(s_ir),
        .in_nibble(s_nib), .in_p(s_p), .in_d(s_d), .out_valid(s_ov), .out_ready(s_or),
        .out_prime_cnt(s_pc), .out_div3_cnt(s_dc), .out_both_cnt(s_bc),
        .out_max_run(s_mr), .err(s_err)
    );

    // Single-sample window instance: CNT_W=8, WIN=1
    logic       w_clear, w_iv, w_ir, w_p, w_d, w_ov, w_or, w_err;
    logic [3:0] w_nib;
    logic [7:0] w_pc, w_dc, w_bc, w_mr;

    prime_div3_stats #(.CNT_W(8), .WIN(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(w_clear), .in_valid(w_iv), .in_ready(w_ir),
        .in_nibble(w_nib), .in_p(w_p), .in_d(w_d), .out_valid(w_ov), .out_ready(w_or),
        .out_prime_cnt(w_pc), .out_div3_cnt(w_dc), .out_both_cnt(w_bc),
        .out_max_run(w_mr), .err(w_err)
    );

    function automatic logic ref_prime(input logic [3:0] n);
        case (n)
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic ref_div3(input logic [3:0] n);
        return (n % 3) == 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample to the main instance and let one edge pass; valid stays high.
    task automatic a_send(input logic [3:0] n, input logic p, input logic d);
        a_iv  = 1'b1;
        a_nib = n;
        a_p   = p;
        a_d   = d;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({a_ov, a_pc, a_dc, a_bc, a_mr, a_err} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {a_ov, a_pc, a_dc, a_bc, a_mr, a_err});
        end
        #20;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (a_ir !== 1'b1 || s_ir !== 1'b1 || w_ir !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b%b%b expected 111", a_ir, s_ir, w_ir);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            a_send(4'(i), ref_prime(4'(i)), ref_div3(4'(i)));
            if (i == 14) begin
                vectors++;
                if (a_ov !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sweep_early_valid: got %b expected 0", a_ov);
                end
            end
        end
        a_iv = 1'b0;
        vectors++;
        if (a_ov !== 1'b1 || a_ir !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_valid_ready: got ov=%b ir=%b expected ov=1 ir=0", a_ov, a_ir);
        end
        vectors++;
        if ({a_pc, a_dc, a_bc, a_mr} !== {8'd6, 8'd6, 8'd1, 8'd2}) begin
            miscompares++;
            $display("FAIL sweep_report: got %h expected 06060102", {a_pc, a_dc, a_bc, a_mr});
        end
        vectors++;
        if (a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_err: got %b expected 0", a_err);
        end
    endtask

    task automatic test_backpressure();
        a_iv  = 1'b1;
        a_nib = 4'd3;
        a_p   = 1'b1;
        a_d   = 1'b1;
        a_or  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (a_ir !== 1'b0 || a_ov !== 1'b1 ||
                {a_pc, a_dc, a_bc, a_mr} !== {8'd6, 8'd6, 8'd1, 8'd2}) begin
                miscompares++;
                $display("FAIL hold_report: cycle %0d ir=%b ov=%b data=%h expected ir=0 ov=1 data=06060102",
                         c, a_ir, a_ov, {a_pc, a_dc, a_bc, a_mr});
            end
        end
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
        a_iv = 1'b0;
        vectors++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake_return: got ov=%b ir=%b expected ov=0 ir=1", a_ov, a_ir);
        end
        vectors++;
        if ({a_pc, a_dc, a_bc, a_mr} !== {8'd6, 8'd6, 8'd1, 8'd2}) begin
            miscompares++;
            $display("FAIL retain_after_handshake: got %h expected 06060102", {a_pc, a_dc, a_bc, a_mr});
        end
    endtask

    task automatic test_all_three();
        for (int i = 0; i < 16; i++) a_send(4'd3, 1'b1, 1'b1);
        a_iv = 1'b0;
        vectors++;
        if (a_ov !== 1'b1 || {a_pc, a_dc, a_bc, a_mr} !== {8'd16, 8'd16, 8'd16, 8'd16}) begin
            miscompares++;
            $display("FAIL all_three_report: got ov=%b data=%h expected ov=1 data=10101010",
                     a_ov, {a_pc, a_dc, a_bc, a_mr});
        end
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
        vectors++;
        if (a_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL all_three_handshake: got %b expected 0", a_ov);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) a_send(4'd2, 1'b1, 1'b0);
        a_clear = 1'b1;
        a_send(4'd2, 1'b1, 1'b0);
        a_clear = 1'b0;
        vectors++;
        if (a_ov !== 1'b0 || {a_pc, a_dc, a_bc, a_mr} !== {8'd16, 8'd16, 8'd16, 8'd16}) begin
            miscompares++;
            $display("FAIL clear_accum: got ov=%b data=%h expected ov=0 data=10101010",
                     a_ov, {a_pc, a_dc, a_bc, a_mr});
        end
        for (int i = 0; i < 16; i++) begin
            a_send(4'd9, 1'b0, 1'b1);
            if (i == 14) begin
                vectors++;
                if (a_ov !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clear_early_valid: got %b expected 0", a_ov);
                end
            end
        end
        a_iv = 1'b0;
        vectors++;
        if (a_ov !== 1'b1 || {a_pc, a_dc, a_bc, a_mr} !== {8'd0, 8'd16, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL clear_fresh_report: got ov=%b data=%h expected ov=1 data=00100000",
                     a_ov, {a_pc, a_dc, a_bc, a_mr});
        end
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        vectors++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1 ||
            {a_pc, a_dc, a_bc, a_mr} !== {8'd0, 8'd16, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL clear_in_report: got ov=%b ir=%b data=%h expected ov=0 ir=1 data=00100000",
                     a_ov, a_ir, {a_pc, a_dc, a_bc, a_mr});
        end
    endtask

    task automatic test_err_and_reset();
        a_send(4'd9, 1'b1, 1'b1);
        a_iv = 1'b0;
        vectors++;
        if (a_err !== ERR_EXP) begin
            miscompares++;
            $display("FAIL err_set: got %b expected %b", a_err, ERR_EXP);
        end
        for (int i = 0; i < 15; i++) a_send(4'd0, 1'b0, 1'b1);
        a_iv = 1'b0;
        vectors++;
        if (a_ov !== 1'b1 || {a_pc, a_dc, a_bc, a_mr} !== {8'd1, 8'd16, 8'd1, 8'd1}) begin
            miscompares++;
            $display("FAIL err_window_report: got ov=%b data=%h expected ov=1 data=01100101",
                     a_ov, {a_pc, a_dc, a_bc, a_mr});
        end
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
        vectors++;
        if (a_err !== ERR_EXP) begin
            miscompares++;
            $display("FAIL err_sticky: got %b expected %b", a_err, ERR_EXP);
        end
        for (int i = 0; i < 3; i++) a_send(4'd5, 1'b1, 1'b0);
        a_iv = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_ov, a_pc, a_dc, a_bc, a_mr, a_err} !== 34'd0 || a_ir !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got %h ir=%b expected 0 ir=1",
                     {a_ov, a_pc, a_dc, a_bc, a_mr, a_err}, a_ir);
        end
        #13;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            a_send(4'd7, 1'b1, 1'b0);
            if (i == 14) begin
                vectors++;
                if (a_ov !== 1'b0) begin
                    miscompares++;
                    $display("FAIL post_reset_early_valid: got %b expected 0", a_ov);
                end
            end
        end
        a_iv = 1'b0;
        vectors++;
        if (a_ov !== 1'b1 || {a_pc, a_dc, a_bc, a_mr} !== {8'd16, 8'd0, 8'd0, 8'd16}) begin
            miscompares++;
            $display("FAIL post_reset_report: got ov=%b data=%h expected ov=1 data=10000010",
                     a_ov, {a_pc, a_dc, a_bc, a_mr});
        end
        vectors++;
        if (a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_err: got %b expected 0", a_err);
        end
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
    endtask

    task automatic test_saturation();
        s_iv  = 1'b1;
        s_nib = 4'd3;
        s_p   = 1'b1;
        s_d   = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 13) begin
                vectors++;
                if (s_ov !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sat_early_valid: got %b expected 0", s_ov);
                end
            end
        end
        s_iv = 1'b0;
        vectors++;
        if (s_ov !== 1'b1 || {s_pc, s_dc, s_bc, s_mr} !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_report: got ov=%b data=%h expected ov=1 data=ffff",
                     s_ov, {s_pc, s_dc, s_bc, s_mr});
        end
        s_or = 1'b1;
        tick();
        s_or = 1'b0;
        vectors++;
        if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_handshake: got ov=%b ir=%b expected ov=0 ir=1", s_ov, s_ir);
        end
    endtask

    task automatic test_win1();
        w_iv  = 1'b1;
        w_nib = 4'd5;
        w_p   = 1'b1;
        w_d   = 1'b0;
        tick();
        w_iv = 1'b0;
        vectors++;
        if (w_ov !== 1'b1 || w_ir !== 1'b0 || {w_pc, w_dc, w_bc, w_mr} !== {8'd1, 8'd0, 8'd0, 8'd1}) begin
            miscompares++;
            $display("FAIL win1_first: got ov=%b ir=%b data=%h expected ov=1 ir=0 data=01000001",
                     w_ov, w_ir, {w_pc, w_dc, w_bc, w_mr});
        end
        w_or = 1'b1;
        tick();
        w_or = 1'b0;
        vectors++;
        if (w_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL win1_handshake: got %b expected 0", w_ov);
        end
        w_iv  = 1'b1;
        w_nib = 4'd6;
        w_p   = 1'b0;
        w_d   = 1'b1;
        tick();
        w_iv = 1'b0;
        vectors++;
        if (w_ov !== 1'b1 || {w_pc, w_dc, w_bc, w_mr} !== {8'd0, 8'd1, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL win1_second: got ov=%b data=%h expected ov=1 data=00010000",
                     w_ov, {w_pc, w_dc, w_bc, w_mr});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_clear = 0; a_iv = 0; a_nib = 0; a_p = 0; a_d = 0; a_or = 0;
        s_clear = 0; s_iv = 0; s_nib = 0; s_p = 0; s_d = 0; s_or = 0;
        w_clear = 0; w_iv = 0; w_nib = 0; w_p = 0; w_d = 0; w_or = 0;
        test_reset();
        test_sweep();
        test_backpressure();
        test_all_three();
        test_clear();
        test_err_and_reset();
        test_saturation();
        test_win1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prime_div3_stats.md
PRIME_DIV3_STATS -- requirements
Module: prime_div3_stats

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the counter and result width in bits (legal range 4..16).
REQ-002 SHALL have parameter WIN, default 16, giving the number of accepted samples per report window (legal range 1..2^CNT_W-1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous abort of the current window.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-008 SHALL have port in_nibble, input, 4 bits: value presented to the upstream classifier.
REQ-009 SHALL have port in_p, input, 1 bit: classifier prime flag.
REQ-010 SHALL have port in_d, input, 1 bit: classifier divisible-by-3 flag.
REQ-011 SHALL have port out_valid, output, 1 bit: report available.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the report.
REQ-013 SHALL have ports out_prime_cnt, out_div3_cnt and out_both_cnt, outputs, CNT_W bits each: window counts.
REQ-014 SHALL have port out_max_run, output, CNT_W bits: longest run of consecutive accepted samples with in_p=1.
REQ-015 SHALL have port err, output, 1 bit: sticky classification-mismatch flag.

Function
REQ-016 SHALL implement a two-state FSM: ACCUM and REPORT.
REQ-017 In ACCUM: in_ready=1 and out_valid=0. A sample is accepted when in_valid=1 and in_ready=1 on a rising edge.
REQ-018 Each accepted sample SHALL increment: the sample count; the prime count if in_p; the div3 count if in_d; the both count if in_p and in_d.
REQ-019 The run counter SHALL increment on each accepted sample with in_p=1 and reset to 0 on each accepted sample with in_p=0. The max register SHALL track the largest run value, including the value produced by the current sample.
REQ-020 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 When the accepted sample makes the sample count equal WIN, the final counts (including that sample) SHALL be latched into the out_* registers. The FSM SHALL enter REPORT on that edge, so out_valid=1 one cycle after the last sample is accepted.
REQ-022 In REPORT: in_ready=0, out_valid=1, and the out_* values SHALL be held stable until handshake.
REQ-023 When out_valid=1 and out_ready=1: all internal counters are cleared, the FSM returns to ACCUM, and out_valid=0 on the next cycle. REPORT therefore lasts at least 1 cycle.
REQ-024 out_* data registers SHALL retain the last report after the handshake.
REQ-025 When in_valid is low, no state changes. Gaps of any length between samples are legal.
REQ-026 clear=1 SHALL have priority over acceptance and handshake: the concurrent sample or report is dropped, internal counters are zeroed and the FSM goes to ACCUM. out_* data and err are not changed.
REQ-027 With WIN=1, every accepted sample SHALL produce a report.

Reset
REQ-028 On rst_n=0, immediately and asynchronously: FSM=ACCUM; all counters, run and max = 0; out_valid=0; out_* = 0; err=0. in_ready SHALL read 1 after release.
REQ-029 Reset mid-window or mid-REPORT SHALL discard all partial state. No report is emitted.

Configuration
REQ-030 Macro PRIME_DIV3_CHECK_EN, when defined, SHALL recompute the prime flag (set {2,3,5,7,11,13}) and the div3 flag (set {0,3,6,9,12,15}) from in_nibble on each accepted sample. Any mismatch with in_p or in_d SHALL set err, which clears only on rst_n. Counting still uses in_p and in_d.
REQ-031 Without PRIME_DIV3_CHECK_EN: err SHALL be tied to 0, in_nibble SHALL be unused, and no checker logic SHALL be synthesized.

Verification
REQ-032 Sweep in_nibble 0..15 with correct flags, WIN=16, back-to-back -> single report: prime=6, div3=6, both=1, max_run=2; err=0.
REQ-033 Hold out_ready=0 for 5 cycles in REPORT while in_valid=1 -> in_ready=0, out_* stable, no sample accepted. Raise out_ready -> ACCUM on the next cycle.
REQ-034 WIN=16, 16 samples of nibble 3 with p=1, d=1 -> prime=div3=both=16, max_run=16. With CNT_W=4 and WIN=15 -> counts saturate at 15.
REQ-035 Assert clear after 7 samples, then send 16 fresh samples -> report reflects only the 16 fresh samples. Assert clear in REPORT -> out_valid drops and the previous out_* data remains.
REQ-036 PRIME_DIV3_CHECK_EN defined, nibble 9 with p=1 -> err=1 next cycle and stays set across later windows. Pulse rst_n low mid-window -> all outputs 0 asynchronously.
